led_blink_ctrl: RTL and testbench

//   Shares the single board LED between NREQ requesters using fixed priority. Each requester

---
 rtl/led_ctrl_pkg.sv | 23 ++
 rtl/led_tick_gen.sv | 75 +++++++
 rtl/led_blink_ctrl.sv | 151 +++++++++++++++
 tb/tb_led_blink_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED blink controller: requester modes, controller states
// and a counter-width helper.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF  = 2'b00,
    LED_ON   = 2'b01,
    LED_SLOW = 2'b10,
    LED_FAST = 2'b11
  } led_mode_e;

  typedef enum logic [1:0] {
    ARB       = 2'b00,
    PULSE_ON  = 2'b01,
    PULSE_OFF = 2'b10
  } ctrl_state_e;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a tick every TICK_DIV clocks, plus the shared
// slow and fast blink phases that every blinking requester follows in lockstep.
module led_tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned SLOW_HALF = 500,
  parameter int unsigned FAST_HALF = 125
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o,
  output logic slow_ph_o,
  output logic fast_ph_o
);

  localparam int unsigned PW = cnt_width(TICK_DIV);
  localparam int unsigned SW = cnt_width(SLOW_HALF);
  localparam int unsigned FW = cnt_width(FAST_HALF);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOW_MAX  = SW'(SLOW_HALF - 1);
  localparam logic [FW-1:0] FAST_MAX  = FW'(FAST_HALF - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] slow_cnt_q, slow_cnt_d;
  logic [FW-1:0] fast_cnt_q, fast_cnt_d;
  logic          slow_ph_q, slow_ph_d;
  logic          fast_ph_q, fast_ph_d;
  logic          tick;

  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    slow_cnt_d = slow_cnt_q;
    slow_ph_d  = slow_ph_q;
    fast_cnt_d = fast_cnt_q;
    fast_ph_d  = fast_ph_q;
    // Phase counters advance on ticks only and clear explicitly at their half-period.
    if (tick) begin
      if (slow_cnt_q == SLOW_MAX) begin
        slow_cnt_d = '0;
        slow_ph_d  = ~slow_ph_q;
      end else begin
        slow_cnt_d = slow_cnt_q + 1'b1;
      end
      if (fast_cnt_q == FAST_MAX) begin
        fast_cnt_d = '0;
        fast_ph_d  = ~fast_ph_q;
      end else begin
        fast_cnt_d = fast_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      slow_cnt_q <= '0;
      fast_cnt_q <= '0;
      slow_ph_q  <= 1'b0;
      fast_ph_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      slow_cnt_q <= slow_cnt_d;
      fast_cnt_q <= fast_cnt_d;
      slow_ph_q  <= slow_ph_d;
      fast_ph_q  <= fast_ph_d;
    end
  end

  assign tick_o    = tick;
  assign slow_ph_o = slow_ph_q;
  assign fast_ph_o = fast_ph_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Fixed-priority LED arbiter: requesters choose OFF/ON/SLOW/FAST, and a one-shot
// pulse burst of N flashes pre-empts them. All outputs are registered.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned SLOW_HALF = 500,
  parameter int unsigned FAST_HALF = 125
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [2*NREQ-1:0] mode_i,
  input  logic              pulse_start_i,
  input  logic [3:0]        pulse_count_i,
  output logic              led_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o
);

  localparam int unsigned PHASE_CYC = FAST_HALF * TICK_DIV;
  localparam int unsigned TW        = cnt_width(PHASE_CYC);
  localparam logic [TW-1:0] TIMER_MAX = TW'(PHASE_CYC - 1);

  ctrl_state_e     state_q, state_d;
  logic [3:0]      count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            led_q, led_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic            slow_ph, fast_ph;
  logic [NREQ-1:0] winner_oh;
  led_mode_e       win_mode;
  logic            found;
  logic            timeout;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .SLOW_HALF(SLOW_HALF),
    .FAST_HALF(FAST_HALF)
  ) u_tick_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tick_o   (),
    .slow_ph_o(slow_ph),
    .fast_ph_o(fast_ph)
  );

  // Lowest-index active requester wins; with no requester the LED is driven off.
  always_comb begin
    winner_oh = '0;
    win_mode  = LED_OFF;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_i[i] && !found) begin
        found        = 1'b1;
        winner_oh[i] = 1'b1;
        win_mode     = led_mode_e'(mode_i[2*i +: 2]);
      end
    end
  end

  assign timeout = (timer_q == TIMER_MAX);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    led_d   = 1'b0;
    busy_d  = busy_q;
    grant_d = '0;
    unique case (state_q)
      ARB: begin
        if (pulse_start_i && (pulse_count_i != 4'd0)) begin
          state_d = PULSE_ON;
          count_d = pulse_count_i;
          timer_d = '0;
          busy_d  = 1'b1;
          led_d   = 1'b1;
        end else begin
          busy_d  = 1'b0;
          grant_d = winner_oh;
          unique case (win_mode)
            LED_OFF:  led_d = 1'b0;
            LED_ON:   led_d = 1'b1;
            LED_SLOW: led_d = slow_ph;
            LED_FAST: led_d = fast_ph;
            default:  led_d = 1'b0;
          endcase
        end
      end
      PULSE_ON: begin
        busy_d = 1'b1;
        if (timeout) begin
          state_d = PULSE_OFF;
          timer_d = '0;
          count_d = count_q - 1'b1;
          led_d   = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
          led_d   = 1'b1;
        end
      end
      PULSE_OFF: begin
        busy_d = 1'b1;
        if (timeout) begin
          timer_d = '0;
          if (count_q != 4'd0) begin
            state_d = PULSE_ON;
            led_d   = 1'b1;
          end else begin
            // Burst finished: one idle cycle, then arbitration drives the outputs again.
            state_d = ARB;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
      count_q <= '0;
      timer_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
    end
  end

  assign led_o   = led_q;
  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl using an arithmetic reference model of the
// blink phases and pulse bursts, with directed scenarios followed by random traffic.
module tb_led_blink_ctrl;

  localparam int NREQ      = 4;
  localparam int TICK_DIV  = 4;
  localparam int SLOW_HALF = 4;
  localparam int FAST_HALF = 2;
  localparam int SLOW_CYC  = SLOW_HALF * TICK_DIV;
  localparam int FAST_CYC  = FAST_HALF * TICK_DIV;
  localparam int PULSE_CYC = FAST_HALF * TICK_DIV;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [7:0]      mode;
  logic            pstart;
  logic [3:0]      pcount;
  logic            led;
  logic [NREQ-1:0] grant;
  logic            busy;

  int nAsserts = 0;
  int nFails   = 0;

  // Reference model state: k counts rising edges since reset release.
  int              k;
  bit              inBurst, endPending;
  int              bj, blen;
  logic            expLed, expBusy;
  logic [NREQ-1:0] expGrant;

  led_blink_ctrl #(
    .NREQ(NREQ), .TICK_DIV(TICK_DIV), .SLOW_HALF(SLOW_HALF), .FAST_HALF(FAST_HALF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .mode_i(mode),
    .pulse_start_i(pstart), .pulse_count_i(pcount),
    .led_o(led), .grant_o(grant), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, update the model from the inputs seen at that edge, sample at +1.
  task automatic cycle();
    logic slowPh, fastPh;
    bit   done;
    @(posedge clk);
    if (!rst_n) begin
      k = 0; inBurst = 0; endPending = 0;
      expLed = 0; expBusy = 0; expGrant = '0;
    end else begin
      k++;
      expLed = 0; expBusy = 0; expGrant = '0;
      if (endPending) begin
        endPending = 0;
      end else if (inBurst) begin
        expBusy = 1;
        expLed  = ((bj / PULSE_CYC) % 2) == 0;
        bj++;
        if (bj == blen) begin inBurst = 0; endPending = 1; end
      end else if (pstart && pcount != 0) begin
        blen = 2 * PULSE_CYC * int'(pcount);
        bj = 1; inBurst = 1;
        expBusy = 1; expLed = 1;
      end else begin
        slowPh = (((k - 1) / SLOW_CYC) % 2) == 1;
        fastPh = (((k - 1) / FAST_CYC) % 2) == 1;
        done = 0;
        for (int i = 0; i < NREQ; i++) begin
          if (req[i] && !done) begin
            done = 1;
            expGrant[i] = 1'b1;
            case (mode[2*i +: 2])
              2'b00:   expLed = 0;
              2'b01:   expLed = 1;
              2'b10:   expLed = slowPh;
              default: expLed = fastPh;
            endcase
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req = 4'b1111; mode = 8'h55; pstart = 0; pcount = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      nAsserts++;
      if ({busy, grant, led} !== 6'b0) begin
        nFails++;
        $display("[TB] FAIL reset_hold got busy/grant/led=%b required 000000", {busy, grant, led});
      end
    end
    rst_n = 1;
    cycle();
    nAsserts++;
    if (grant !== 4'b0001 || led !== 1'b1 || busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_release got grant=%b led=%b busy=%b required 0001/1/0", grant, led, busy);
    end
  endtask

  task automatic test_priority();
    req = 4'b1100; mode = 8'b01_10_00_00;
    for (int c = 0; c < 40; c++) begin
      cycle();
      nAsserts++;
      if ({busy, grant, led} !== {expBusy, expGrant, expLed}) begin
        nFails++;
        $display("[TB] FAIL priority_slow k=%0d got %b required %b", k, {busy, grant, led}, {expBusy, expGrant, expLed});
      end
    end
    req = 4'b1101; mode[1:0] = 2'b00;
    cycle();
    nAsserts++;
    if (grant !== 4'b0001 || led !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL priority_req0 got grant=%b led=%b required 0001/0", grant, led);
    end
  endtask

  task automatic test_lockstep();
    req = 4'b0010; mode = 8'b00_00_11_00;
    for (int c = 0; c < 33; c++) begin
      if (c == 13) begin req = 4'b0100; mode = 8'b00_11_00_00; end
      cycle();
      nAsserts++;
      if ({busy, grant, led} !== {expBusy, expGrant, expLed}) begin
        nFails++;
        $display("[TB] FAIL lockstep k=%0d got %b required %b", k, {busy, grant, led}, {expBusy, expGrant, expLed});
      end
    end
  endtask

  task automatic test_pulse();
    int busyCycles = 0;
    req = 4'b0011; mode = 8'b00_00_01_01;
    pstart = 1; pcount = 3;
    for (int c = 0; c < 60; c++) begin
      cycle();
      pstart = 0;
      if (busy === 1'b1) busyCycles++;
      nAsserts++;
      if ({busy, grant, led} !== {expBusy, expGrant, expLed}) begin
        nFails++;
        $display("[TB] FAIL pulse c=%0d got %b required %b", c, {busy, grant, led}, {expBusy, expGrant, expLed});
      end
    end
    nAsserts++;
    if (busyCycles !== 48) begin
      nFails++;
      $display("[TB] FAIL pulse_len got %0d cycles required 48", busyCycles);
    end
  endtask

  task automatic test_ignored();
    int busyCycles = 0;
    req = 4'b1000; mode = 8'b01_00_00_00;
    pstart = 1; pcount = 0;
    cycle();
    pstart = 0;
    nAsserts++;
    if (busy !== 1'b0 || grant !== 4'b1000 || led !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL zero_count got busy=%b grant=%b led=%b required 0/1000/1", busy, grant, led);
    end
    pstart = 1; pcount = 3;
    for (int c = 0; c < 60; c++) begin
      cycle();
      pstart = (c == 10); pcount = (c == 10) ? 4'd5 : 4'd3;
      if (busy === 1'b1) busyCycles++;
      nAsserts++;
      if ({busy, grant, led} !== {expBusy, expGrant, expLed}) begin
        nFails++;
        $display("[TB] FAIL restrobe c=%0d got %b required %b", c, {busy, grant, led}, {expBusy, expGrant, expLed});
      end
    end
    nAsserts++;
    if (busyCycles !== 48) begin
      nFails++;
      $display("[TB] FAIL restrobe_len got %0d cycles required 48", busyCycles);
    end
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0001; mode = 8'h01;
    pstart = 1; pcount = 2;
    for (int c = 0; c < 20; c++) begin
      cycle();
      pstart = 0;
    end
    rst_n = 0;
    #1;
    nAsserts++;
    if ({busy, grant, led} !== 6'b0) begin
      nFails++;
      $display("[TB] FAIL midburst_reset got %b required 000000", {busy, grant, led});
    end
    cycle();
    cycle();
    rst_n = 1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      nAsserts++;
      if ({busy, grant, led} !== {expBusy, expGrant, expLed} || busy !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL after_reset c=%0d got %b required %b", c, {busy, grant, led}, {expBusy, expGrant, expLed});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      req    = NREQ'($urandom_range(0, 15));
      mode   = 8'($urandom);
      pstart = ($urandom_range(0, 39) == 0);
      pcount = 4'($urandom_range(0, 3));
      cycle();
      nAsserts++;
      if ({busy, grant, led} !== {expBusy, expGrant, expLed}) begin
        nFails++;
        $display("[TB] FAIL random k=%0d got %b required %b", k, {busy, grant, led}, {expBusy, expGrant, expLed});
      end
    end
    pstart = 0;
  endtask

  initial begin
    k = 0; inBurst = 0; endPending = 0; bj = 0; blen = 0;
    expLed = 0; expBusy = 0; expGrant = '0;
    test_reset();
    test_priority();
    test_lockstep();
    test_pulse();
    test_ignored();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
